// File: rtl/pipe_pkg.sv
// Shared pipeline bundle types for the EX->MEM boundary.
// Also holds the writeback-source encoding and buffer occupancy states.
package pipe_pkg;

  localparam int XLEN = 32;
  localparam int PCW  = 32;
  localparam int REGW = 5;

  typedef enum logic [1:0] {
    ALU = 2'd0,
    MEM = 2'd1,
    PC4 = 2'd2
  } result_src_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] w_data;
    logic [REGW-1:0] rd;
    logic [PCW-1:0]  pc_plus4;
    logic [2:0]      func3;
    logic            reg_write;
    result_src_e     result_src;
    logic            mem_write;
  } ex_mem_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Elastic two-entry pipeline register with registered in_ready.
// Main entry drives the output; skid catches one bundle under backpressure.
module pipe_skid_buf #(
  parameter type T       = logic [31:0],
  parameter bit  SKID_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);
  import pipe_pkg::*;

  occ_e occ_q, occ_d;
  T     main_q, main_d;
  T     skid_q, skid_d;
  logic rdy_q, rdy_d;
  logic push, pop;

  assign out_valid = (occ_q != EMPTY);
  assign out_data  = main_q;

  // rdy_q also holds in_ready low through reset in the single-entry mode
  assign in_ready = SKID_EN ? rdy_q
                  : (rdy_q && (!out_valid || out_ready));

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    unique case (occ_q)
      EMPTY: begin
        if (push) begin
          main_d = in_data;
          occ_d  = ONE;
        end
      end
      ONE: begin
        unique case (1'b1)
          (push && pop): main_d = in_data;
          (push && !pop && SKID_EN): begin
            skid_d = in_data;
            occ_d  = FULL;
          end
          (pop && !push): occ_d = EMPTY;
          default: ;
        endcase
      end
      FULL: begin
        if (pop) begin
          main_d = skid_q;
          occ_d  = ONE;
        end
      end
      default: occ_d = EMPTY;
    endcase
    // flush keeps stale data visible but invalid
    if (flush) begin
      occ_d  = EMPTY;
      main_d = main_q;
      skid_d = skid_q;
    end
    rdy_d = SKID_EN ? (occ_d != FULL) : 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
      skid_q <= skid_d;
      rdy_q  <= rdy_d;
    end
  end

endmodule

// File: rtl/pipereg_ex_mem_elastic.sv
// EX->MEM elastic pipeline register: packs the bundle into the skid buffer.
// Control outputs are masked to zero whenever no valid bundle is held.
module pipereg_ex_mem_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int PC_WIDTH   = PCW,
  parameter int REG_WIDTH  = REGW,
  parameter bit SKID_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] alu_res_in,
  input  logic [DATA_WIDTH-1:0] w_data_in,
  input  logic [REG_WIDTH-1:0]  rd_in,
  input  logic [PC_WIDTH-1:0]   pc_plus4_in,
  input  logic [2:0]            func3_in,
  input  logic                  reg_write_in,
  input  logic [1:0]            result_src_in,
  input  logic                  mem_write_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_res_out,
  output logic [DATA_WIDTH-1:0] w_data_out,
  output logic [REG_WIDTH-1:0]  rd_out,
  output logic [PC_WIDTH-1:0]   pc_plus4_out,
  output logic [2:0]            func3_out,
  output logic                  reg_write_out,
  output logic [1:0]            result_src_out,
  output logic                  mem_write_out
);

  ex_mem_t in_b;
  ex_mem_t out_b;
  logic    vld;

  always_comb begin
    in_b            = '0;
    in_b.alu_res    = alu_res_in;
    in_b.w_data     = w_data_in;
    in_b.rd         = rd_in;
    in_b.pc_plus4   = pc_plus4_in;
    in_b.func3      = func3_in;
    in_b.reg_write  = reg_write_in;
    in_b.result_src = result_src_e'(result_src_in);
    in_b.mem_write  = mem_write_in;
  end

  pipe_skid_buf #(
    .T       (ex_mem_t),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_b),
    .out_valid (vld),
    .out_ready (out_ready),
    .out_data  (out_b)
  );

  assign out_valid    = vld;
  assign alu_res_out  = out_b.alu_res;
  assign w_data_out   = out_b.w_data;
  assign rd_out       = out_b.rd;
  assign pc_plus4_out = out_b.pc_plus4;
  assign func3_out    = out_b.func3;

  assign reg_write_out  = vld & out_b.reg_write;
  assign result_src_out = vld ? out_b.result_src : 2'b00;
  assign mem_write_out  = vld & out_b.mem_write;

endmodule
